// File: rtl/msx_pkg.sv
// Shared constants and types for the MSX1 Z80 bus controller.
// Holds the slot port address, the open-bus value and the M1 wait FSM states.
package msx_pkg;

    localparam logic [7:0] SLOT_PORT = 8'hA8;
    localparam logic [7:0] OPEN_BUS  = 8'hFF;

    typedef logic [1:0] slot_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } waitState_e;

    // Each 16 KB page owns a 2-bit field of the primary slot register.
    function automatic slot_t pageSlot(input logic [7:0] slotReg, input logic [1:0] page);
        return slotReg[2*page +: 2];
    endfunction

endpackage

// File: rtl/msx_bus_ctrl_if.sv
// Z80-side bus and memory-side data signals of the MSX bus controller.
// The slave modport is the controller; the master modport is the CPU/memory side.
interface msx_bus_if;

    logic        ce_3m58_p;
    logic        ce_3m58_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_mreq_n;
    logic        cpu_iorq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic        cpu_m1_n;
    logic        cpu_rfsh_n;
    logic [7:0]  cpu_di;
    logic        cpu_wait_n;
    logic [7:0]  rom_q;
    logic [7:0]  ram_q;
    logic        ram_we;
    logic [7:0]  slot_reg;

    modport slave (
        input  ce_3m58_p, ce_3m58_n, cpu_a, cpu_do,
        input  cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n,
        input  rom_q, ram_q,
        output cpu_di, cpu_wait_n, ram_we, slot_reg
    );

    modport master (
        output ce_3m58_p, ce_3m58_n, cpu_a, cpu_do,
        output cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n,
        output rom_q, ram_q,
        input  cpu_di, cpu_wait_n, ram_we, slot_reg
    );

endinterface

// File: rtl/msx_bus_ctrl_wait_gen.sv
// M1 wait-state generator: pulls WAIT low for M1_WAIT CPU clock ticks
// at the start of every opcode fetch, then holds off until M1 ends.
module msx_wait_gen
    import msx_pkg::*;
#(
    parameter int unsigned M1_WAIT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce_3m58_p,
    input  logic m1_n,
    input  logic mreq_n,
    output logic wait_n
);

    waitState_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       waitN_q, waitN_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            waitN_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waitN_q <= waitN_d;
        end
    end

    // HOLD keeps a long M1 from re-triggering once its wait has been served.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waitN_d = waitN_q;
        case (state_q)
            ST_IDLE: begin
                if ((M1_WAIT > 0) && ce_3m58_p && !m1_n && !mreq_n) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'(M1_WAIT);
                    waitN_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (ce_3m58_p) begin
                    if (cnt_q == 8'd1) begin
                        state_d = ST_HOLD;
                        waitN_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (m1_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                waitN_d = 1'b1;
            end
        endcase
    end

    assign wait_n = waitN_q;

endmodule

// File: rtl/msx_bus_ctrl.sv
// MSX1 Z80 bus controller: primary slot register at port A8h, page-to-slot
// decode, CPU read data steering, RAM write strobe and M1 wait insertion.
module msx_bus_ctrl
    import msx_pkg::*;
#(
    parameter int unsigned ROM_SLOT = 0,
    parameter int unsigned RAM_SLOT = 3,
    parameter int unsigned M1_WAIT  = 1
) (
    input logic        clk,
    input logic        reset_n,
    msx_bus_if.slave   bus
);

    logic       wrN_q, wrNPrev_q;
    logic [7:0] slotReg_q, slotReg_d;
    logic       ramWe_q, ramWe_d;
    logic       wrFall;
    logic [1:0] page;
    slot_t      activeSlot;
    logic       slotPortHit, ioAccess, memAccess, romHit, ramHit;
    logic [7:0] cpuDi;
    logic       waitN;
    logic       unusedBits;

    assign unusedBits = ^{bus.ce_3m58_n, bus.cpu_a[13:8]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrN_q     <= 1'b1;
            wrNPrev_q <= 1'b1;
            slotReg_q <= 8'h00;
            ramWe_q   <= 1'b0;
        end else begin
            wrN_q     <= bus.cpu_wr_n;
            wrNPrev_q <= wrN_q;
            slotReg_q <= slotReg_d;
            ramWe_q   <= ramWe_d;
        end
    end

    assign wrFall      = wrNPrev_q & ~wrN_q;
    assign page        = bus.cpu_a[15:14];
    assign activeSlot  = pageSlot(slotReg_q, page);
    assign slotPortHit = (bus.cpu_a[7:0] == SLOT_PORT);
    assign ioAccess    = !bus.cpu_iorq_n && bus.cpu_m1_n;
    assign memAccess   = !bus.cpu_mreq_n && bus.cpu_rfsh_n;
    assign romHit      = (activeSlot == 2'(ROM_SLOT)) && !page[1];
    assign ramHit      = (activeSlot == 2'(RAM_SLOT));

    // ROM is checked first so it shadows RAM when both share a slot.
    always_comb begin
        slotReg_d = slotReg_q;
        ramWe_d   = 1'b0;
        cpuDi     = OPEN_BUS;
        if (wrFall && !bus.cpu_wr_n && ioAccess && slotPortHit) begin
            slotReg_d = bus.cpu_do;
        end
        if (wrFall && !bus.cpu_wr_n && memAccess && ramHit) begin
            ramWe_d = 1'b1;
        end
        if (!bus.cpu_rd_n) begin
            if (ioAccess && slotPortHit) begin
                cpuDi = slotReg_q;
            end else if (memAccess) begin
                if (romHit) begin
                    cpuDi = bus.rom_q;
                end else if (ramHit) begin
                    cpuDi = bus.ram_q;
                end
            end
        end
    end

    msx_wait_gen #(
        .M1_WAIT (M1_WAIT)
    ) uWaitGen (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce_3m58_p (bus.ce_3m58_p),
        .m1_n      (bus.cpu_m1_n),
        .mreq_n    (bus.cpu_mreq_n),
        .wait_n    (waitN)
    );

    assign bus.cpu_di     = cpuDi;
    assign bus.cpu_wait_n = waitN;
    assign bus.ram_we     = ramWe_q;
    assign bus.slot_reg   = slotReg_q;

endmodule

// File: tb/tb_msx_bus_ctrl.sv
// Scoreboard bench for msx_bus_ctrl: three instances (standard map, no M1 wait,
// ROM and RAM sharing slot 0) driven by one set of directed Z80 bus cycles.
module tb_msx_bus_ctrl;

    localparam int K_DI   = 0;
    localparam int K_SLOT = 1;
    localparam int K_WAIT = 2;
    localparam int K_WLOW = 3;
    localparam int K_WE   = 4;

    typedef struct {
        string       name;
        int          which;
        int          kind;
        logic [31:0] expVal;
    } sbItem_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic        ceP, ceN;
    logic [15:0] cpuA;
    logic [7:0]  cpuDo;
    logic        mreqN, iorqN, rdN, wrN, m1N, rfshN;
    logic [7:0]  romQ, ramQ;
    logic [7:0]  cpuDi   [3];
    logic [7:0]  slotReg [3];
    logic        waitN   [3];
    logic        ramWe   [3];
    int          waitLowCnt [3];
    int          weCnt      [3];
    int          cePhase;
    int          checks;
    int          fails;
    int          b0, b1, b2;
    sbItem_t     sbQ[$];

    always #5 clk = ~clk;

    msx_bus_if bus[3] ();

    for (genvar g = 0; g < 3; g++) begin : gConn
        assign bus[g].ce_3m58_p  = ceP;
        assign bus[g].ce_3m58_n  = ceN;
        assign bus[g].cpu_a      = cpuA;
        assign bus[g].cpu_do     = cpuDo;
        assign bus[g].cpu_mreq_n = mreqN;
        assign bus[g].cpu_iorq_n = iorqN;
        assign bus[g].cpu_rd_n   = rdN;
        assign bus[g].cpu_wr_n   = wrN;
        assign bus[g].cpu_m1_n   = m1N;
        assign bus[g].cpu_rfsh_n = rfshN;
        assign bus[g].rom_q      = romQ;
        assign bus[g].ram_q      = ramQ;
        assign cpuDi[g]          = bus[g].cpu_di;
        assign slotReg[g]        = bus[g].slot_reg;
        assign waitN[g]          = bus[g].cpu_wait_n;
        assign ramWe[g]          = bus[g].ram_we;
    end

    msx_bus_ctrl #(.ROM_SLOT(0), .RAM_SLOT(3), .M1_WAIT(1)) dutMain (
        .clk(clk), .reset_n(resetN), .bus(bus[0]));
    msx_bus_ctrl #(.ROM_SLOT(0), .RAM_SLOT(3), .M1_WAIT(0)) dutNoWait (
        .clk(clk), .reset_n(resetN), .bus(bus[1]));
    msx_bus_ctrl #(.ROM_SLOT(0), .RAM_SLOT(0), .M1_WAIT(1)) dutShared (
        .clk(clk), .reset_n(resetN), .bus(bus[2]));

    // CPU clock enables: rising phase every 4th clk, falling phase half-way between.
    initial begin
        cePhase = 3;
        ceP = 1'b0;
        ceN = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cePhase = (cePhase + 1) % 4;
            ceP = (cePhase == 0);
            ceN = (cePhase == 2);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            waitLowCnt[i] = 0;
            weCnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (waitN[i] === 1'b0) waitLowCnt[i]++;
                if (ramWe[i] === 1'b1) weCnt[i]++;
            end
        end
    end

    initial begin
        sbItem_t     item;
        logic [31:0] actual;
        forever begin
            @(negedge clk);
            while (sbQ.size() > 0) begin
                item = sbQ.pop_front();
                case (item.kind)
                    K_DI:    actual = 32'(cpuDi[item.which]);
                    K_SLOT:  actual = 32'(slotReg[item.which]);
                    K_WAIT:  actual = 32'(waitN[item.which]);
                    K_WLOW:  actual = 32'(waitLowCnt[item.which]);
                    default: actual = 32'(weCnt[item.which]);
                endcase
                checks++;
                if (actual !== item.expVal) begin
                    fails++;
                    $display("[TB] FAIL %s dut%0d: got %0h, expected %0h",
                             item.name, item.which, actual, item.expVal);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int which, input int kind,
                               input logic [31:0] expVal);
        sbItem_t item;
        item.name   = name;
        item.which  = which;
        item.kind   = kind;
        item.expVal = expVal;
        sbQ.push_back(item);
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 4 && sbQ.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sbQ.size() > 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard_drain: %0d items left, expected 0", sbQ.size());
            sbQ.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                                 input logic mreq, input logic iorq, input logic rd,
                                 input logic wr, input logic m1, input logic rfsh,
                                 input int holdClks);
        cpuA  = a;
        cpuDo = d;
        mreqN = mreq;
        iorqN = iorq;
        rdN   = rd;
        wrN   = wr;
        m1N   = m1;
        rfshN = rfsh;
        repeat (holdClks) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        applyStimulus(16'h0000, 8'h00, 1, 1, 1, 1, 1, 1, n);
    endtask

    task automatic ioWrite(input logic [15:0] a, input logic [7:0] d);
        applyStimulus(a, d, 1, 0, 1, 0, 1, 1, 4);
        idle(2);
    endtask

    task automatic memWrite(input logic [15:0] a, input logic [7:0] d, input logic rfsh);
        applyStimulus(a, d, 0, 1, 1, 0, 1, rfsh, 4);
        idle(3);
    endtask

    task automatic m1Fetch(input int holdClks);
        applyStimulus(16'h0000, 8'h00, 0, 1, 0, 1, 0, 1, holdClks);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        checks = 0;
        fails  = 0;
        resetN = 1'b0;
        romQ   = 8'hF3;
        ramQ   = 8'h5A;
        cpuA   = 16'h0000;
        cpuDo  = 8'h00;
        mreqN = 1; iorqN = 1; rdN = 1; wrN = 1; m1N = 1; rfshN = 1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_slot", i, K_SLOT, 32'h00);
            checkOutput("reset_wait", i, K_WAIT, 32'h1);
        end
        checkOutput("reset_idle_di", 0, K_DI, 32'hFF);
        waitDrain();
        resetN = 1'b1;
        idle(2);

        applyStimulus(16'h0000, 8'h00, 0, 1, 0, 1, 1, 1, 1);
        checkOutput("rd_rom_0000", 0, K_DI, 32'hF3);
        checkOutput("shared_rom_0000", 2, K_DI, 32'hF3);
        waitDrain();
        idle(1);
        applyStimulus(16'h8000, 8'h00, 0, 1, 0, 1, 1, 1, 1);
        checkOutput("rd_empty_8000", 0, K_DI, 32'hFF);
        checkOutput("shared_ram_8000", 2, K_DI, 32'h5A);
        waitDrain();
        idle(1);

        b0 = waitLowCnt[0]; b1 = waitLowCnt[1]; b2 = waitLowCnt[2];
        m1Fetch(2);
        checkOutput("m1_fetch_di", 0, K_DI, 32'hF3);
        waitDrain();
        m1Fetch(14);
        idle(2);
        checkOutput("m1_wait_one_tick", 0, K_WLOW, 32'(b0 + 4));
        checkOutput("m1_wait_disabled", 1, K_WLOW, 32'(b1));
        checkOutput("m1_wait_shared", 2, K_WLOW, 32'(b2 + 4));
        checkOutput("m1_wait_released", 0, K_WAIT, 32'h1);
        waitDrain();

        applyStimulus(16'h00A8, 8'h00, 1, 0, 0, 1, 0, 1, 1);
        checkOutput("int_ack_di", 0, K_DI, 32'hFF);
        waitDrain();
        idle(2);

        ioWrite(16'h12A8, 8'hA5);
        checkOutput("slot_write_a5", 0, K_SLOT, 32'hA5);
        waitDrain();
        ioWrite(16'h0099, 8'h3C);
        checkOutput("slot_other_port", 0, K_SLOT, 32'hA5);
        waitDrain();
        applyStimulus(16'h00A8, 8'h00, 1, 0, 0, 1, 1, 1, 1);
        checkOutput("io_read_slot", 0, K_DI, 32'hA5);
        waitDrain();
        idle(1);
        applyStimulus(16'h0099, 8'h00, 1, 0, 0, 1, 1, 1, 1);
        checkOutput("io_read_99", 0, K_DI, 32'hFF);
        waitDrain();
        idle(1);

        ioWrite(16'h00A8, 8'hF0);
        applyStimulus(16'hC000, 8'h00, 0, 1, 0, 1, 1, 1, 1);
        checkOutput("rd_ram_c000", 0, K_DI, 32'h5A);
        waitDrain();
        idle(1);
        applyStimulus(16'h0000, 8'h00, 0, 1, 0, 1, 1, 1, 1);
        checkOutput("rd_rom_slot_f0", 0, K_DI, 32'hF3);
        waitDrain();
        idle(1);

        ioWrite(16'h00A8, 8'hFF);
        b0 = weCnt[0]; b2 = weCnt[2];
        memWrite(16'h4000, 8'h55, 1'b1);
        checkOutput("we_ram_slot", 0, K_WE, 32'(b0 + 1));
        checkOutput("we_shared_empty", 2, K_WE, 32'(b2));
        waitDrain();
        b0 = weCnt[0];
        memWrite(16'h4000, 8'h55, 1'b0);
        checkOutput("we_refresh", 0, K_WE, 32'(b0));
        waitDrain();
        ioWrite(16'h00A8, 8'h00);
        b0 = weCnt[0]; b2 = weCnt[2];
        memWrite(16'h4000, 8'h55, 1'b1);
        checkOutput("we_rom_slot", 0, K_WE, 32'(b0));
        checkOutput("we_shared_ram", 2, K_WE, 32'(b2 + 1));
        waitDrain();

        ioWrite(16'h00A8, 8'hFF);
        m1Fetch(0);
        k = 0;
        while (waitN[0] !== 1'b0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (waitN[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wait_low_timeout: wait_n=%b, expected 0", waitN[0]);
        end
        resetN = 1'b0;
        checkOutput("reset_mid_wait", 0, K_WAIT, 32'h1);
        checkOutput("reset_mid_slot", 0, K_SLOT, 32'h00);
        waitDrain();
        idle(2);
        resetN = 1'b1;
        idle(2);

        b0 = waitLowCnt[0];
        m1Fetch(16);
        idle(2);
        checkOutput("m1_after_reset", 0, K_WLOW, 32'(b0 + 4));
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
